// File: rtl/branch_predictor_pkg.sv
// Shared branch-prediction types: 2-bit counter encodings, reset state and default geometry.
// Used by the predictor itself and by the fetch and branch-resolution logic.
package branch_predictor_pkg;

  localparam int unsigned PC_W               = 32;
  localparam int unsigned BP_DEFAULT_ENTRIES = 16;
  localparam int unsigned BP_DEFAULT_CNT_W   = 16;

  typedef enum logic [1:0] {
    CNT_SNT = 2'b00,
    CNT_WNT = 2'b01,
    CNT_WT  = 2'b10,
    CNT_ST  = 2'b11
  } bp_cnt_e;

  localparam bp_cnt_e BP_CNT_RESET = CNT_WNT;

  // Resolved-branch payload carried from EX back to the predictor.
  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic            taken;
    logic [PC_W-1:0] target;
    logic            pred_taken;
  } bp_update_t;

  // Taken prediction is the counter's upper half (WT, ST).
  function automatic logic bp_predict_taken(input bp_cnt_e cnt);
    return (cnt == CNT_WT) || (cnt == CNT_ST);
  endfunction

  // Counter value given to a freshly allocated entry.
  function automatic bp_cnt_e bp_alloc_cnt(input logic taken);
    return taken ? CNT_WT : CNT_WNT;
  endfunction

endpackage

// File: rtl/bp_sat_counter.sv
// Next-state function of a 2-bit saturating branch counter.
module bp_sat_counter
  import branch_predictor_pkg::*;
(
  input  logic [1:0] state,
  input  logic       taken,
  output logic [1:0] next_state_c
);

  always_comb begin
    next_state_c = state;
    case (state)
      CNT_SNT: next_state_c = taken ? CNT_WNT : CNT_SNT;
      CNT_WNT: next_state_c = taken ? CNT_WT  : CNT_SNT;
      CNT_WT:  next_state_c = taken ? CNT_ST  : CNT_WNT;
      CNT_ST:  next_state_c = taken ? CNT_ST  : CNT_WT;
      default: next_state_c = state;
    endcase
  end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped 2-bit branch predictor with target buffer and a saturating mispredict counter.
// Lookup is combinational; updates from EX land on the rising edge ending the strobe cycle.
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int unsigned ENTRIES = BP_DEFAULT_ENTRIES,
  parameter int unsigned CNT_W   = BP_DEFAULT_CNT_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       IF_PC,
  output logic              IF_BPred,
  output logic              IF_BPredValid,
  output logic [31:0]       IF_BPredTarget,
  input  logic              EX_Update,
  input  logic [31:0]       EX_PC,
  input  logic              EX_Taken,
  input  logic [31:0]       EX_Target,
  input  logic              EX_PredTaken,
  output logic [CNT_W-1:0]  BP_MissCount
);

  localparam int unsigned IDX   = $clog2(ENTRIES);
  localparam int unsigned TAG_W = PC_W - 2 - IDX;

  // Entry storage as flop arrays.
  logic             valid_q  [ENTRIES];
  logic [TAG_W-1:0] tag_q    [ENTRIES];
  logic [PC_W-1:0]  target_q [ENTRIES];
  bp_cnt_e          cnt_q    [ENTRIES];
  logic [CNT_W-1:0] miss_q;

  // Fetch-side lookup.
  logic [IDX-1:0]   if_idx;
  logic [TAG_W-1:0] if_tag;
  logic             if_hit;

  assign if_idx = IF_PC[2 +: IDX];
  assign if_tag = IF_PC[2 + IDX +: TAG_W];
  assign if_hit = valid_q[if_idx] && (tag_q[if_idx] == if_tag);

  assign IF_BPredValid  = if_hit;
  assign IF_BPred       = if_hit && bp_predict_taken(cnt_q[if_idx]);
  assign IF_BPredTarget = if_hit ? target_q[if_idx] : '0;

  // Resolution-side update request.
  bp_update_t       ex;
  logic [IDX-1:0]   ex_idx;
  logic [TAG_W-1:0] ex_tag;
  logic             ex_hit;
  logic             ex_mispredict;

  assign ex.pc         = EX_PC;
  assign ex.taken      = EX_Taken;
  assign ex.target     = EX_Target;
  assign ex.pred_taken = EX_PredTaken;

  assign ex_idx        = ex.pc[2 +: IDX];
  assign ex_tag        = ex.pc[2 + IDX +: TAG_W];
  assign ex_hit        = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);
  assign ex_mispredict = EX_Update && (ex.pred_taken != ex.taken);

  logic [1:0] cnt_next_c;

  bp_sat_counter u_sat_counter (
    .state        (cnt_q[ex_idx]),
    .taken        (ex.taken),
    .next_state_c (cnt_next_c)
  );

  // New contents for the indexed entry: train on a hit, reallocate on a miss.
  logic [TAG_W-1:0] wr_tag;
  logic [PC_W-1:0]  wr_target;
  bp_cnt_e          wr_cnt;

  always_comb begin
    wr_tag    = ex_tag;
    wr_target = ex.target;
    wr_cnt    = bp_alloc_cnt(ex.taken);
    if (ex_hit) begin
      wr_tag    = tag_q[ex_idx];
      wr_target = ex.taken ? ex.target : target_q[ex_idx];
      wr_cnt    = bp_cnt_e'(cnt_next_c);
    end
  end

  // Table state; reset clears everything regardless of a pending update.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        cnt_q[i]    <= BP_CNT_RESET;
      end
    end else if (EX_Update) begin
      valid_q[ex_idx]  <= 1'b1;
      tag_q[ex_idx]    <= wr_tag;
      target_q[ex_idx] <= wr_target;
      cnt_q[ex_idx]    <= wr_cnt;
    end
  end

  // Mispredict statistics, saturating at all-ones.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      miss_q <= '0;
    end else if (ex_mispredict && (miss_q != {CNT_W{1'b1}})) begin
      miss_q <= miss_q + CNT_W'(1);
    end
  end

  assign BP_MissCount = miss_q;

  logic unused_pc_bits;
  assign unused_pc_bits = ^{IF_PC[1:0], ex.pc[1:0]};

endmodule
